// File: rtl/counter_stream_checker.sv
// counter_stream_checker
//   Receive-side monitor for a free-running up-counter bus. Checks that every
//   enabled sample is the previous sample + 1 (mod 2^N). It declares lock after
//   LOCK_CYCLES consecutive good steps. It pulses and counts discontinuities
//   seen while locked, and counts all-ones -> 0 wraps seen while locked.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   en         sample qualifier; count_in is only looked at when en=1
//   count_in   [N-1:0]      monitored counter value
//   locked     high while in LOCKED
//   err_pulse  one-cycle pulse per loss of lock
//   err_count  [ERR_W-1:0]  saturating loss-of-lock count
//   wrap_count [WRAP_W-1:0] wraps seen while locked (modulo 2^WRAP_W)
//   expected   [N-1:0]      prediction of the next sample
module counter_stream_checker #(
  parameter int N           = 36,
  parameter int LOCK_CYCLES = 4,
  parameter int ERR_W       = 8,
  parameter int WRAP_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [N-1:0]      count_in,
  output logic              locked,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_count,
  output logic [WRAP_W-1:0] wrap_count,
  output logic [N-1:0]      expected
);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

  localparam logic [7:0]        LOCK_C   = 8'(LOCK_CYCLES);
  localparam logic [7:0]        CNT_ONE  = 8'd1;
  localparam logic [N-1:0]      N_ONE    = N'(1);
  localparam logic [ERR_W-1:0]  ERR_ONE  = ERR_W'(1);
  localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);

  state_t            state_q, state_d;
  logic [N-1:0]      prev_q, prev_d;
  logic [7:0]        match_q, match_d;
  logic              locked_d, pulse_d;
  logic [ERR_W-1:0]  err_d;
  logic [WRAP_W-1:0] wrap_d;
  logic [N-1:0]      exp_d;

  logic [N-1:0] prev_inc;
  logic [7:0]   match_inc;
  logic         good;
  logic         prev_all_ones;

  assign prev_inc      = prev_q + N_ONE;
  assign match_inc     = match_q + CNT_ONE;
  // prev_inc wraps naturally, so all-ones -> 0 counts as good
  assign good          = (count_in == prev_inc);
  assign prev_all_ones = (prev_q == '1);

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    match_d  = match_q;
    locked_d = locked;
    pulse_d  = 1'b0;
    err_d    = err_count;
    wrap_d   = wrap_count;
    exp_d    = expected;
    if (en) begin
      prev_d = count_in;
      exp_d  = count_in + N_ONE;
      unique case (state_q)
        IDLE: begin
          // first sample only seeds prev; never compared
          match_d = '0;
          state_d = ACQUIRE;
        end
        ACQUIRE: begin
          if (good) begin
            match_d = match_inc;
            if (match_inc == LOCK_C) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          if (good) begin
            if (prev_all_ones) wrap_d = wrap_count + WRAP_ONE;
          end else begin
            pulse_d  = 1'b1;
            if (err_count != '1) err_d = err_count + ERR_ONE;
            locked_d = 1'b0;
            match_d  = '0;
            state_d  = ACQUIRE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      match_q    <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
      expected   <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      match_q    <= match_d;
      locked     <= locked_d;
      err_pulse  <= pulse_d;
      err_count  <= err_d;
      wrap_count <= wrap_d;
      expected   <= exp_d;
    end
  end

endmodule

// File: tb/tb_counter_stream_checker.sv
// Bench for counter_stream_checker. Two instances share the stimulus:
// a default one (LOCK_CYCLES=4, ERR_W=8) and a small one (LOCK_CYCLES=1,
// ERR_W=2) that reaches error saturation quickly. A behavioural model per
// instance predicts every output after every edge.
module tb_counter_stream_checker;

  localparam longint unsigned MASK = 64'h0000_000F_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [35:0] count_in;

  logic        locked0, pulse0, locked1, pulse1;
  logic [7:0]  err0;
  logic [1:0]  err1;
  logic [15:0] wrap0, wrap1;
  logic [35:0] exp0, exp1;

  counter_stream_checker #(.N(36), .LOCK_CYCLES(4), .ERR_W(8), .WRAP_W(16)) dut0 (
    .clk(clk), .reset(reset), .en(en), .count_in(count_in),
    .locked(locked0), .err_pulse(pulse0), .err_count(err0),
    .wrap_count(wrap0), .expected(exp0)
  );

  counter_stream_checker #(.N(36), .LOCK_CYCLES(1), .ERR_W(2), .WRAP_W(16)) dut1 (
    .clk(clk), .reset(reset), .en(en), .count_in(count_in),
    .locked(locked1), .err_pulse(pulse1), .err_count(err1),
    .wrap_count(wrap1), .expected(exp1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model, one slot per instance
  int               lock_need [2] = '{4, 1};
  int               err_max   [2] = '{255, 3};
  int               m_phase   [2]; // 0 = no sample yet, 1 = acquiring, 2 = locked
  int               m_run     [2];
  longint unsigned  m_prev    [2];
  longint unsigned  m_exp     [2];
  int               m_err     [2];
  int               m_wrap    [2];
  bit               m_lock    [2];
  bit               m_pulse   [2];
  bit               last_pulse[2];

  task automatic chk(input string tag, input longint unsigned obs, input longint unsigned req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = 0; m_run[i] = 0; m_prev[i] = 0; m_exp[i] = 0;
      m_err[i] = 0; m_wrap[i] = 0; m_lock[i] = 0; m_pulse[i] = 0;
      last_pulse[i] = 0;
    end
  endtask

  task automatic model_step(input bit e, input longint unsigned s);
    for (int i = 0; i < 2; i++) begin
      m_pulse[i] = 0;
      if (e) begin
        if (m_phase[i] == 0) begin
          m_run[i] = 0;
          m_phase[i] = 1;
        end else if (s == ((m_prev[i] + 1) & MASK)) begin
          if (m_phase[i] == 1) begin
            m_run[i]++;
            if (m_run[i] == lock_need[i]) begin
              m_phase[i] = 2;
              m_lock[i] = 1;
            end
          end else if (m_prev[i] == MASK) begin
            m_wrap[i] = (m_wrap[i] + 1) % 65536;
          end
        end else begin
          m_run[i] = 0;
          if (m_phase[i] == 2) begin
            m_pulse[i] = 1;
            m_err[i] = (m_err[i] < err_max[i]) ? m_err[i] + 1 : err_max[i];
            m_lock[i] = 0;
            m_phase[i] = 1;
          end
        end
        m_prev[i] = s;
        m_exp[i] = (s + 1) & MASK;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " d0.locked"},     locked0, m_lock[0]);
    chk({tag, " d0.err_pulse"},  pulse0,  m_pulse[0]);
    chk({tag, " d0.err_count"},  err0,    longint'(m_err[0]));
    chk({tag, " d0.wrap_count"}, wrap0,   longint'(m_wrap[0]));
    chk({tag, " d0.expected"},   exp0,    m_exp[0]);
    chk({tag, " d1.locked"},     locked1, m_lock[1]);
    chk({tag, " d1.err_pulse"},  pulse1,  m_pulse[1]);
    chk({tag, " d1.err_count"},  err1,    longint'(m_err[1]));
    chk({tag, " d1.wrap_count"}, wrap1,   longint'(m_wrap[1]));
    chk({tag, " d1.expected"},   exp1,    m_exp[1]);
    if (last_pulse[0]) chk({tag, " d0.pulse_b2b"}, pulse0, 0);
    if (last_pulse[1]) chk({tag, " d1.pulse_b2b"}, pulse1, 0);
    last_pulse[0] = pulse0;
    last_pulse[1] = pulse1;
  endtask

  // drive on the falling edge, sample 1 time unit after the rising edge
  task automatic step(input string tag, input bit e, input longint unsigned v);
    @(negedge clk);
    en = e;
    count_in = v[35:0];
    @(posedge clk);
    model_step(e, v);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    en = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  longint unsigned cur;
  bit              e;
  int              r;

  initial begin
    reset = 1'b1;
    en = 1'b0;
    count_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_state");
    do_reset();

    // lock on a clean stream
    for (int v = 0; v <= 4; v++) step("lock", 1, v);
    chk("lock locked", locked0, 1);
    chk("lock expected", exp0, 5);
    chk("lock err_count", err0, 0);

    // break and relock
    step("break", 1, 5);
    step("break", 1, 7);
    chk("break pulse", pulse0, 1);
    chk("break err_count", err0, 1);
    chk("break locked", locked0, 0);
    for (int v = 8; v <= 11; v++) step("relock", 1, v);
    chk("relock locked", locked0, 1);
    chk("relock err_count", err0, 1);

    // jump near all-ones, relock, then wrap while locked
    for (longint unsigned v = MASK - 6; v <= MASK; v++) step("wrap", 1, v);
    for (int v = 0; v <= 2; v++) step("wrap", 1, v);
    chk("wrap wrap_count", wrap0, 1);
    chk("wrap expected", exp0, 3);
    chk("wrap locked", locked0, 1);

    // enable gap with junk on the bus
    for (int v = 3; v <= 20; v++) step("pre_gap", 1, v);
    for (int k = 0; k < 3; k++) step("gap", 0, 999);
    chk("gap expected", exp0, 21);
    step("gap_resume", 1, 21);
    chk("gap locked", locked0, 1);
    chk("gap pulse", pulse0, 0);

    // async reset between edges while locked with err_count=2
    chk("pre_async err_count", err0, 2);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("async_reset");
    chk("async locked", locked0, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int v = 0; v <= 4; v++) step("post_reset", 1, v);
    chk("post_reset locked", locked0, 1);

    // saturation on the ERR_W=2 / LOCK_CYCLES=1 instance
    do_reset();
    step("sat", 1, 0);
    step("sat", 1, 1);
    cur = 1;
    for (int k = 0; k < 5; k++) begin
      cur = cur + 10;
      step("sat_break", 1, cur);
      chk("sat pulse", pulse1, 1);
      chk("sat err_count", err1, (k < 3) ? k + 1 : 3);
      cur = cur + 1;
      step("sat_relock", 1, cur);
      chk("sat relocked", locked1, 1);
    end

    // randomized stream: mostly +1, with jumps, repeats, gaps and wraps
    cur = 100;
    for (int n = 0; n < 3000; n++) begin
      e = ($urandom_range(0, 9) < 8);
      if (e) begin
        r = $urandom_range(0, 99);
        if (r < 3)      cur = {$urandom, $urandom} & MASK;
        else if (r < 5) cur = MASK - $urandom_range(0, 6);
        else if (r < 7) cur = cur;
        else            cur = (cur + 1) & MASK;
        step("rand", 1, cur);
      end else begin
        step("rand_gap", 0, {$urandom, $urandom} & MASK);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // independent time limit so the run always ends
  initial begin
    #400000;
    errors++;
    $display("FAIL timeout checks=%0d", checks);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_stream_checker.md
Name: counter_stream_checker

Overview:
- Receive-side monitor for the free-running up-counter outputs of the counter cluster (8/12/16/36-bit async-reset counters).
- Samples one counter bus and checks that it advances by exactly +1 modulo 2^N per enabled cycle.
- Declares lock after a run of good steps, flags and counts discontinuities, and counts wrap-arounds.
- Instantiated next to counter clusters as a self-check for the counter benchmarks.

Parameters:
- N, 36, width of the monitored counter bus.
- LOCK_CYCLES, 4, consecutive good +1 steps required to enter LOCKED (legal range 1..255).
- ERR_W, 8, width of the saturating error counter.
- WRAP_W, 16, width of the wrap counter (wraps modulo 2^WRAP_W).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  sample qualifier; count_in is sampled only on edges where en=1.
- count_in  input  N  monitored counter value.
- locked  output  1  high while the FSM is in LOCKED.
- err_pulse  output  1  one-cycle pulse on a discontinuity detected while LOCKED.
- err_count  output  ERR_W  saturating count of discontinuities detected while LOCKED.
- wrap_count  output  WRAP_W  count of all-ones -> 0 transitions seen while LOCKED.
- expected  output  N  registered prediction of the next sample (prev + 1 mod 2^N).

Behaviour:
- Reset is asynchronous and active-high.
  - While reset=1, all outputs are 0 and the FSM is IDLE, independent of clk.
  - Internal prev and match_cnt are also 0.
  - Reset asserted mid-operation clears everything immediately.
- All outputs are registered. Sample s is taken at edge k; results are visible after edge k.
- en=0: every register holds, except err_pulse, which is 0. Values on count_in are ignored.
- Define good = (s == prev + 1 mod 2^N). The all-ones -> 0 transition is good.
- Every enabled edge loads prev <= s and expected <= s + 1 mod 2^N.
- FSM states:
  - IDLE, on an enabled edge:
    - match_cnt <= 0.
    - Go to ACQUIRE. The first sample is never compared.
  - ACQUIRE, on an enabled edge:
    - If good: match_cnt <= match_cnt + 1. When match_cnt + 1 == LOCK_CYCLES, go to LOCKED and set locked <= 1.
    - If not good: match_cnt <= 0 and stay in ACQUIRE.
    - No error or wrap counting in this state.
  - LOCKED, good sample:
    - Stay in LOCKED.
    - If prev == all-ones (so s == 0): wrap_count <= wrap_count + 1, modulo 2^WRAP_W.
  - LOCKED, not-good sample:
    - err_pulse <= 1 for exactly one cycle.
    - err_count <= err_count + 1, saturating at 2^ERR_W - 1.
    - locked <= 0, match_cnt <= 0, go to ACQUIRE.
- A repeated value (s == prev) is not good.
- Back-to-back mismatches after an error are only resync failures in ACQUIRE, so one pulse per loss of lock.
- Lock latency from reset release with a clean stream: locked rises at the edge of the (LOCK_CYCLES+1)th enabled sample.
- err_pulse is never high on two consecutive cycles.

Test Plan:
- Lock: N=36, LOCK_CYCLES=4. Release reset, en=1, count_in=0,1,2,3,4 on successive edges -> locked=1 after the 5th edge, expected=5, err_count=0.
- Break: while locked, feed 5, then 7 -> err_pulse=1 for one cycle, err_count=1, locked=0. Then feed 8,9,10,11 -> locked=1 again, err_count stays 1.
- Wrap: while locked, feed 2^36-2, 2^36-1, 0, 1 -> wrap_count=1, err_pulse never asserted, expected=2.
- Gaps: while locked with prev=20, drop en for 3 cycles with count_in=999, then en=1 with 21 -> no error, still locked, state held during the gap.
- Saturation: ERR_W=2, LOCK_CYCLES=1. Cause 5 lock-then-break events -> err_count reads 1,2,3,3,3 with 5 err_pulses.
- Async reset: while locked with err_count=2, assert reset between clock edges -> all outputs 0 immediately. After release, 0,1,2,3,4 relocks.
